led_share_arbiter: RTL

- Shares one LED bank between NREQ requesters, e.g. status, error and heartbeat blocks that each want to drive the board LEDs.
- Arbitration is round-robin with a time slice: the owner keeps the bank while it requests, until its slice expires and another requester is waiting.
- A 1 ms tick prescaler, derived from the clock frequency, times each slice.
- Sits between the pattern producers (blinkers, status encoders) and the top-level LED pins.

---
 rtl/led_share_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/led_share_arbiter.sv
// led_share_arbiter: round-robin time-sliced owner of one LED bank.
// Ports: clk, rst (sync, active-low), req/pattern in; gnt/led/busy out.
module led_share_arbiter #(
  parameter int LED      = 4,
  parameter int NREQ     = 4,
  parameter int CLKFREQ  = 100,
  parameter int SLICE_MS = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*LED-1:0] pattern,
  output logic [NREQ-1:0]     gnt,
  output logic [LED-1:0]      led,
  output logic                busy
);

  localparam int TICK = CLKFREQ * 1000;
  localparam int PW   = $clog2(TICK);
  localparam int SW   = $clog2(SLICE_MS + 1);
  localparam int IW   = $clog2(NREQ);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [LED-1:0]  led_q;
  logic            busy_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   owner_q;
  logic [PW-1:0]   pre_q;
  logic [SW-1:0]   slc_q;

  logic            win_vld_d;
  logic [IW-1:0]   win_d;
  logic [IW-1:0]   ptr_d;
  logic            tick_d;
  logic            expire_d;
  logic            contend_d;
  logic            release_d;
  int unsigned     j;

  // first requester at or after ptr, wrapping
  always_comb begin
    win_vld_d = 1'b0;
    win_d     = '0;
    j         = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr_q) + k) % NREQ;
      if (!win_vld_d && req[j]) begin
        win_vld_d = 1'b1;
        win_d     = IW'(j);
      end
    end
  end

  always_comb begin
    tick_d    = (pre_q == PW'(TICK - 1));
    expire_d  = tick_d && (slc_q == SW'(SLICE_MS - 1));
    contend_d = |(req & ~gnt_q);
    release_d = !req[owner_q] || (expire_d && contend_d);
    ptr_d     = (owner_q == IW'(NREQ - 1)) ?
                '0 : owner_q + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
      owner_q <= '0;
      pre_q   <= '0;
      slc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          pre_q <= '0;
          slc_q <= '0;
          if (win_vld_d) begin
            state_q <= OWN;
            gnt_q   <= NREQ'(1) << win_d;
            owner_q <= win_d;
            led_q   <= pattern[int'(win_d)*LED +: LED];
            busy_q  <= 1'b1;
          end else begin
            gnt_q  <= '0;
            led_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        OWN: begin
          if (release_d) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            pre_q   <= '0;
            slc_q   <= '0;
          end else begin
            led_q <= pattern[int'(owner_q)*LED +: LED];
            if (tick_d) begin
              pre_q <= '0;
              // uncontested expiry restarts the slice
              if (expire_d) slc_q <= '0;
              else          slc_q <= slc_q + SW'(1);
            end else begin
              pre_q <= pre_q + PW'(1);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          led_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign led  = led_q;
  assign busy = busy_q;

endmodule
